// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and default address map.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: load extract/extend from a stored word and
// store byte-enables plus lane-replicated write data.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] wlanes_o
);

  logic [15:0] sel;

  // Low 16 bits after shifting the addressed lane down to bit 0
  assign sel = 16'(word_i >> {lane_i, 3'b000});

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{sel[7]}}, sel[7:0]};
      F3_H:    rdata_o = {{16{sel[15]}}, sel};
      F3_W:    rdata_o = word_i;
      F3_BU:   rdata_o = {24'd0, sel[7:0]};
      F3_HU:   rdata_o = {16'd0, sel};
      default: rdata_o = '0;
    endcase
  end

  always_comb begin
    be_o     = '0;
    wlanes_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        be_o     = 4'b0001 << lane_i;
        wlanes_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o     = 4'b0011 << {lane_i[1], 1'b0};
        wlanes_o = {2{wdata_i[15:0]}};
      end
      F3_W:    be_o = 4'b1111;
      default: be_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target: commits stores at acceptance, captures
// load data/error immediately, presents the response after LATENCY cycles.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [31:0]     offset;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            accept, in_range, bad_f3, misalign, acc_err;
  logic [31:0]     ld_data, wlanes;
  logic [3:0]      be;

  // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail the range test
  assign offset   = req_addr - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign lane     = offset[1:0];
  assign in_range = {1'b0, offset} < SPAN;
  assign bad_f3   = req_write ? (req_funct3 > F3_W)
                              : (req_funct3 inside {3'b011, 3'b110, 3'b111});
  assign misalign = (req_funct3[1:0] == 2'b01 && lane[0]) ||
                    (req_funct3[1:0] == 2'b10 && lane != 2'b00);
  assign acc_err  = !in_range || bad_f3 || misalign;
  assign accept   = req_valid && req_ready;

  dmem_lane_align u_align (
    .word_i   (mem_q[idx]),
    .lane_i   (lane),
    .funct3_i (req_funct3),
    .wdata_i  (req_wdata),
    .rdata_o  (ld_data),
    .be_o     (be),
    .wlanes_o (wlanes)
  );

  // Storage is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (accept && req_write && !acc_err) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem_q[idx][8*k +: 8] <= wlanes[8*k +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rdata_q <= (req_write || acc_err) ? 32'd0 : ld_data;
        err_q   <= acc_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY == 1) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 2);
        end
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 1'b1;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = reset && (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_error = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses LATENCY=1, instance 1
// LATENCY=4; a byte-map model plus a per-cycle monitor checks both.
module tb_dmem_responder;

  localparam int LAT [2] = '{1, 4};

  logic             clock;
  logic             reset;
  logic [1:0]       req_valid, req_write, rsp_ready;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][2:0]  req_funct3;
  logic [1:0]       req_ready, rsp_valid, rsp_error;
  logic [1:0][31:0] rsp_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0100_0000), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0100_0000), .LATENCY(4)) u_l4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed model of each instance's storage
  logic [7:0] mm [longint unsigned];

  function automatic void model(input int d, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                output logic [31:0] rd, output bit err);
    logic [31:0] off, v;
    int nb;
    longint unsigned key;
    off = addr - 32'h0100_0000;
    nb  = 1 << f3[1:0];
    err = (off >= 32'd4096) ||
          (wr && f3 > 3'd2) || (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
          (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off[1:0] != 2'd0);
    rd = 32'd0;
    if (err) return;
    key = (longint'(d) << 32) | longint'(off);
    if (wr) begin
      for (int i = 0; i < nb; i++) mm[key + longint'(i)] = wdata[8*i +: 8];
      return;
    end
    v = 32'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[key + longint'(i)];
    case (f3)
      3'd0: rd = {{24{v[7]}}, v[7:0]};
      3'd1: rd = {{16{v[15]}}, v[15:0]};
      3'd4: rd = {24'd0, v[7:0]};
      3'd5: rd = {16'd0, v[15:0]};
      default: rd = v;
    endcase
  endfunction

  // Per-cycle monitor: handshake timing, latency and response contents
  bit          armed = 0, rst_prev = 0;
  bit          pend [2] = '{0, 0};
  int          wcnt [2] = '{0, 0};
  logic [31:0] erd  [2];
  bit          eerr [2];

  always @(negedge clock) begin
    if (!armed) begin
      armed    = (reset == 1'b0);
      rst_prev = reset;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!rst_prev) begin
          chk("mon_rst_valid", 32'(rsp_valid[d]), 32'd0);
          chk("mon_rst_rdata", rsp_rdata[d], 32'd0);
          chk("mon_rst_error", 32'(rsp_error[d]), 32'd0);
        end
        chk("mon_req_ready", 32'(req_ready[d]), 32'(reset && !pend[d]));
        if (!reset) pend[d] = 0;
        else if (pend[d]) begin
          wcnt[d]++;
          chk("mon_latency", 32'(rsp_valid[d]), 32'(wcnt[d] >= LAT[d]));
          if (rsp_valid[d]) begin
            chk("mon_rdata", rsp_rdata[d], erd[d]);
            chk("mon_error", 32'(rsp_error[d]), 32'(eerr[d]));
            if (rsp_ready[d]) pend[d] = 0;
          end
        end else if (rst_prev) chk("mon_idle_valid", 32'(rsp_valid[d]), 32'd0);
        if (reset && req_valid[d] && req_ready[d]) begin
          model(d, req_write[d], req_addr[d], req_wdata[d], req_funct3[d], erd[d], eerr[d]);
          pend[d] = 1;
          wcnt[d] = 0;
        end
      end
      rst_prev = reset;
    end
  end

  task automatic drive(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata;
    req_funct3[d] = f3; req_valid[d] = 1'b1;
  endtask

  // Waits for acceptance; returns with the request accepted at the last posedge
  task automatic wait_accept(input int d, input string nm);
    int t = 0;
    @(negedge clock);
    while (!req_ready[d] && t < 20) begin @(negedge clock); t++; end
    if (!req_ready[d]) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clock); #1 req_valid[d] = 1'b0;
  endtask

  task automatic xact(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      input logic [31:0] exp_rd, input bit exp_err,
                      input int stall, input string nm);
    int t = 0;
    drive(d, wr, addr, wdata, f3);
    wait_accept(d, nm);
    @(negedge clock);
    while (!rsp_valid[d] && t < 20) begin @(negedge clock); t++; end
    chk({nm, "_valid"}, 32'(rsp_valid[d]), 32'd1);
    chk({nm, "_rdata"}, rsp_rdata[d], exp_rd);
    chk({nm, "_error"}, 32'(rsp_error[d]), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1 drive(d, 1'b1, 32'h0100_0020, 32'h1234_5678, 3'd2);
      @(negedge clock);
      chk({nm, "_stall_rdata"}, rsp_rdata[d], exp_rd);
      chk({nm, "_stall_ready"}, 32'(req_ready[d]), 32'd0);
    end
    @(posedge clock); #1 req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
    @(posedge clock); #1 rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = '1; req_write = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata[0], 32'd0);
    chk("rst_error", 32'(rsp_error), 32'd0);
    @(posedge clock); #1 req_valid = '0; reset = 1'b1;
    @(negedge clock);
    chk("rel_req_ready", 32'(req_ready), 32'd3);
    @(posedge clock); #1;

    // LATENCY=1 instance: data path and errors
    xact(0, 1, 32'h0100_0010, 32'hDEAD_BEEF, 3'd2, 32'h0, 0, 0, "sw");
    xact(0, 0, 32'h0100_0010, 32'h0, 3'd2, 32'hDEAD_BEEF, 0, 0, "lw");
    xact(0, 0, 32'h0100_0013, 32'h0, 3'd0, 32'hFFFF_FFDE, 0, 0, "lb");
    xact(0, 0, 32'h0100_0013, 32'h0, 3'd4, 32'h0000_00DE, 0, 0, "lbu");
    xact(0, 0, 32'h0100_0010, 32'h0, 3'd1, 32'hFFFF_BEEF, 0, 0, "lh");
    xact(0, 0, 32'h0100_0012, 32'h0, 3'd5, 32'h0000_DEAD, 0, 0, "lhu");
    xact(0, 1, 32'h0100_0011, 32'hAAAA_AA55, 3'd0, 32'h0, 0, 0, "sb");
    xact(0, 0, 32'h0100_0010, 32'h0, 3'd2, 32'hDEAD_55EF, 0, 0, "lw_sb");
    xact(0, 1, 32'h0100_0012, 32'h0000_7A5C, 3'd1, 32'h0, 0, 0, "sh");
    xact(0, 0, 32'h0100_0010, 32'h0, 3'd2, 32'h7A5C_55EF, 0, 0, "lw_sh");
    xact(0, 1, 32'h0100_0000, 32'h1122_3344, 3'd2, 32'h0, 0, 0, "sw_base");
    xact(0, 0, 32'h0100_0002, 32'h0, 3'd2, 32'h0, 1, 0, "lw_mis");
    xact(0, 0, 32'h0100_0001, 32'h0, 3'd1, 32'h0, 1, 0, "lh_mis");
    xact(0, 0, 32'h00FF_FFFC, 32'h0, 3'd2, 32'h0, 1, 0, "lw_below");
    xact(0, 0, 32'h0100_1000, 32'h0, 3'd2, 32'h0, 1, 0, "lw_above");
    xact(0, 0, 32'h0100_0FFC, 32'h0, 3'd2, 32'h0, 0, 0, "lw_last");
    xact(0, 0, 32'h0100_0000, 32'h0, 3'd3, 32'h0, 1, 0, "ld_badf3");
    xact(0, 1, 32'h0100_0000, 32'h0, 3'd4, 32'h0, 1, 0, "st_badf3");
    xact(0, 1, 32'h0100_0002, 32'hFFFF_FFFF, 3'd2, 32'h0, 1, 0, "sw_mis");
    xact(0, 0, 32'h0100_0000, 32'h0, 3'd2, 32'h1122_3344, 0, 0, "lw_unch");

    // LATENCY=4 instance: stall, ignored requests, mid-operation reset
    xact(1, 1, 32'h0100_0020, 32'hCAFE_F00D, 3'd2, 32'h0, 0, 0, "l4_sw");
    xact(1, 0, 32'h0100_0020, 32'h0, 3'd2, 32'hCAFE_F00D, 0, 3, "l4_lw_stall");
    xact(1, 0, 32'h0100_0020, 32'h0, 3'd2, 32'hCAFE_F00D, 0, 0, "l4_no_capture");

    drive(1, 1, 32'h0100_0030, 32'hA5A5_A5A5, 3'd2);
    wait_accept(1, "l4_sw_rst");
    reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("l4_rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    @(posedge clock); #1;
    xact(1, 0, 32'h0100_0030, 32'h0, 3'd2, 32'hA5A5_A5A5, 0, 0, "l4_lw_after_rst");

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the RISC-V core's load/store path. It is the target side of the core's memory request interface. It accepts one request at a time from the core's memory stage and performs byte/half/word access with RISC-V size and sign semantics on a little-endian byte array. After a programmable latency it returns a registered response (load data or store acknowledge) with an error flag.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two)
BASE_ADDR, 32'h01000000, byte address mapped to storage offset 0
LATENCY, 1, cycles from request acceptance to rsp_valid (must be >= 1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
req_valid  input  1  core presents a request
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; the relevant lane is taken from the low bits
req_funct3  input  3  RISC-V funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
rsp_valid  output  1  response available
rsp_ready  input  1  core accepts the response
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_error  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Clock is clock. Reset is synchronous and active-low: when reset==0 at a rising edge, state goes to IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE (and only when reset==1).
- Acceptance: req_valid && req_ready at a rising edge.
- On acceptance:
  - The store write commits at that same edge.
  - Load data and the error flag are captured into the response registers at that edge.
  - A later request cannot alter a captured response.
- After acceptance: if LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-2. WAIT decrements the counter and moves to RESP when the counter==0.
- rsp_valid = 1 exactly in RESP. Outputs hold stable until rsp_ready==1 at an edge, then the FSM returns to IDLE.
- The earliest next acceptance is the cycle after the handshake, so back-to-back throughput is LATENCY+1 cycles per request.
- Address: offset = req_addr - BASE_ADDR (32-bit unsigned). The access is in range iff offset < DEPTH_WORDS*4. Word index = offset[log2(DEPTH_WORDS)+1:2]; lane = offset[1:0].
- Error conditions (any one sets rsp_error=1):
  - halfword with offset[0]!=0
  - word with offset[1:0]!=0
  - out of range
  - load funct3 in {011,110,111}
  - store funct3 > 010
- On error: no memory write occurs and rsp_rdata=0.
- Loads:
  - LB/LH sign-extend the selected byte/half.
  - LBU/LHU zero-extend.
  - LW returns the whole word.
  - Byte lane k is bits [8k+7:8k].
- Stores:
  - SB writes req_wdata[7:0] to lane offset[1:0].
  - SH writes req_wdata[15:0] to lanes offset[1]*2 and offset[1]*2+1.
  - SW writes all four lanes.
  - Other lanes are unchanged.
  - Store response has rsp_rdata=0.
- req_valid while not IDLE is ignored; the request is not captured. The core holds the request until req_ready.
- Reset mid-operation (WAIT or RESP): the pending response is discarded. A store already committed at acceptance stays written.
- Address wrap: a req_addr below BASE_ADDR wraps to a large offset and is reported as out of range.

Decomposition:
- Shared package holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum (IDLE, WAIT, RESP)
  - default BASE_ADDR
- One natural sub-module: dmem_lane_align. It is combinational and does two things:
  - load extract and extend from {word, lane, funct3}
  - store byte-enable and lane-data merge from {wdata, lane, funct3}
- The FSM, counter, storage array and error checks stay in dmem_responder.

Test Plan:
- Reset held low 2 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0; released -> req_ready=1 next cycle.
- SW 0xDEADBEEF to 0x01000010, then LW 0x01000010 (LATENCY=1) -> each rsp_valid exactly 1 cycle after acceptance; store rsp_rdata=0; load rsp_rdata=0xDEADBEEF, rsp_error=0.
- After the SW above: LB 0x01000013 -> 0xFFFFFFDE; LBU 0x01000013 -> 0x000000DE; LH 0x01000010 -> 0xFFFFBEEF; SB 0x55 to 0x01000011, then LW -> 0xDEAD55EF.
- LW at 0x01000002, LH at 0x01000001, LW at 0x00FFFFFC, LW at BASE_ADDR+DEPTH_WORDS*4 -> rsp_error=1, rsp_rdata=0; SW at 0x01000002 followed by LW 0x01000000 -> original word unchanged.
- LATENCY=4, rsp_ready held 0 for 3 cycles in RESP -> rsp_valid rises 4 cycles after acceptance, outputs stable while stalled, req_ready=0 until the cycle after the handshake; req_valid pulses during the stall are not captured.
- Reset asserted in WAIT after an accepted SW -> no response appears; subsequent LW returns the stored value.
